// File: rtl/mvm_pkg.sv
// Shared types and arithmetic helpers for the sparsity-aware spiking layer.
package mvm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    UPDATE = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  // Signed add clamped to the range of a w-bit two's-complement value.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned w);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = {a[31], a} + {b[31], b};
    hi  = (33'sd1 <<< (w - 32'd1)) - 33'sd1;
    lo  = -(33'sd1 <<< (w - 32'd1));
    if (sum > hi) begin
      return 32'(hi);
    end else if (sum < lo) begin
      return 32'(lo);
    end else begin
      return 32'(sum);
    end
  endfunction

  function automatic int unsigned lsb_index(input logic [31:0] vec);
    int unsigned idx;
    idx = 32'd0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 32'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/lif_update.sv
// One leaky-integrate-and-fire neuron: leak, saturate, threshold, reset.
// Refractory counter is present only when REFRACTORY_EN is defined.
module lif_update
  import mvm_pkg::*;
#(
  parameter int V_W          = 8,
  parameter int ACC_W        = 10,
  parameter int THRESH       = 64,
  parameter int LEAK_SHIFT   = 1,
  parameter int REFRAC_STEPS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [V_W-1:0]   v,
  output logic                    spike
);

  logic signed [V_W-1:0] v_r;
  logic                  spike_r;
  logic signed [31:0]    v_ext_s;
  logic signed [31:0]    leaked_s;
  logic signed [31:0]    sum_s;
  logic signed [V_W-1:0] v_new_s;
  logic                  fire_s;

  // The leak is subtracted before saturation so only the final sum clamps.
  always_comb begin
    v_ext_s  = 32'(v_r);
    leaked_s = v_ext_s - (v_ext_s >>> LEAK_SHIFT);
    sum_s    = sat_add(leaked_s, 32'(acc), V_W);
    v_new_s  = V_W'(sum_s);
    fire_s   = (sum_s >= THRESH);
  end

`ifdef REFRACTORY_EN
  localparam int RC_W = $clog2(REFRAC_STEPS + 1);
  logic [RC_W-1:0] rc_r;

  // Membrane update with refractory hold after a spike.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_r     <= {V_W{1'b0}};
      spike_r <= 1'b0;
      rc_r    <= {RC_W{1'b0}};
    end else if (en) begin
      if (rc_r != {RC_W{1'b0}}) begin
        v_r     <= {V_W{1'b0}};
        spike_r <= 1'b0;
        rc_r    <= rc_r - {{(RC_W-1){1'b0}}, 1'b1};
      end else if (fire_s) begin
        v_r     <= {V_W{1'b0}};
        spike_r <= 1'b1;
        rc_r    <= RC_W'(REFRAC_STEPS);
      end else begin
        v_r     <= v_new_s;
        spike_r <= 1'b0;
      end
    end
  end
`else
  // Membrane update; the neuron may fire on any timestep.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_r     <= {V_W{1'b0}};
      spike_r <= 1'b0;
    end else if (en) begin
      if (fire_s) begin
        v_r     <= {V_W{1'b0}};
        spike_r <= 1'b1;
      end else begin
        v_r     <= v_new_s;
        spike_r <= 1'b0;
      end
    end
  end
`endif

  assign v     = v_r;
  assign spike = spike_r;

endmodule

// File: rtl/mvm_lif_array.sv
// Sparsity-aware N_IN x N_OUT spiking layer: accumulates one set input row per
// cycle, then leaks/fires all neurons. Optional refractory via REFRACTORY_EN.
module mvm_lif_array
  import mvm_pkg::*;
#(
  parameter int N_IN         = 8,
  parameter int N_OUT        = 4,
  parameter int W_W          = 4,
  parameter int V_W          = 8,
  parameter int THRESH       = 64,
  parameter int LEAK_SHIFT   = 1,
  parameter int REFRAC_STEPS = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N_IN-1:0]                  in_spikes,
  input  logic                             w_we,
  input  logic [$clog2(N_IN*N_OUT)-1:0]    w_addr,
  input  logic signed [W_W-1:0]            w_data,
  output logic                             out_valid,
  output logic [N_OUT-1:0]                 out_spikes,
  output logic [N_OUT*V_W-1:0]             out_vmem,
  output logic                             busy
);

  localparam int N_W    = N_IN * N_OUT;
  localparam int ADDR_W = $clog2(N_W);
  localparam int ROW_W  = $clog2(N_IN);
  localparam int ACC_W  = V_W + 2;

  logic signed [W_W-1:0]   w_r [N_W];
  state_t                  state_r;
  state_t                  state_s;
  logic [N_IN-1:0]         mask_r;
  logic [N_IN-1:0]         mask_s;
  logic signed [ACC_W-1:0] acc_r [N_OUT];
  logic signed [ACC_W-1:0] acc_s [N_OUT];
  logic [ROW_W-1:0]        row_s;
  logic                    in_ready_r;
  logic                    busy_r;
  logic                    out_valid_r;
  logic                    w_ok_s;
  logic                    upd_s;

  // Next-state, mask consumption and row accumulation.
  always_comb begin
    state_s = state_r;
    mask_s  = mask_r;
    acc_s   = acc_r;
    row_s   = ROW_W'(lsb_index(32'(mask_r)));
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          mask_s = in_spikes;
          for (int j = 0; j < N_OUT; j++) begin
            acc_s[j] = {ACC_W{1'b0}};
          end
          state_s = (in_spikes != {N_IN{1'b0}}) ? ACCUM : UPDATE;
        end else begin
          state_s = IDLE;
        end
      end
      ACCUM: begin
        for (int j = 0; j < N_OUT; j++) begin
          acc_s[j] = acc_r[j] + ACC_W'(w_r[ADDR_W'(int'(row_s) * N_OUT + j)]);
        end
        mask_s[row_s] = 1'b0;
        state_s = (mask_s == {N_IN{1'b0}}) ? UPDATE : ACCUM;
      end
      UPDATE:  state_s = OUTPUT;
      OUTPUT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Control state and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      mask_r      <= {N_IN{1'b0}};
      acc_r       <= '{default: {ACC_W{1'b0}}};
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      mask_r      <= mask_s;
      acc_r       <= acc_s;
      in_ready_r  <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
      out_valid_r <= (state_s == OUTPUT);
    end
  end

  // Weight writes only land in IDLE, so a coincident accept sees the new value.
  always_comb begin
    w_ok_s = w_we && (state_r == IDLE) && ({1'b0, w_addr} < (ADDR_W + 1)'(N_W));
    upd_s  = (state_r == UPDATE);
  end

  // Weight matrix storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_r <= '{default: {W_W{1'b0}}};
    end else if (w_ok_s) begin
      w_r[w_addr] <= w_data;
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
    lif_update #(
      .V_W         (V_W),
      .ACC_W       (ACC_W),
      .THRESH      (THRESH),
      .LEAK_SHIFT  (LEAK_SHIFT),
      .REFRAC_STEPS(REFRAC_STEPS)
    ) u_lif (
      .clk  (clk),
      .rst  (rst),
      .en   (upd_s),
      .acc  (acc_r[j]),
      .v    (out_vmem[j*V_W +: V_W]),
      .spike(out_spikes[j])
    );
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mvm_lif_array.sv
// Randomised + directed bench for mvm_lif_array with a timestep-level model.
// Two DUTs share stimulus: default leak (LEAK_SHIFT=1) and LEAK_SHIFT=7.
module tb_mvm_lif_array;

  localparam int NW     = 32;
  localparam int THR    = 64;
  localparam int REFRAC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_spikes = 8'h00;
  logic       w_we = 1'b0;
  logic [4:0] w_addr = 5'd0;
  logic [3:0] w_data = 4'd0;

  logic        a_in_ready, a_out_valid, a_busy;
  logic [3:0]  a_out_spikes;
  logic [31:0] a_out_vmem;
  logic        b_in_ready, b_out_valid, b_busy;
  logic [3:0]  b_out_spikes;
  logic [31:0] b_out_vmem;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mvm_lif_array u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_spikes(in_spikes), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .out_valid(a_out_valid), .out_spikes(a_out_spikes), .out_vmem(a_out_vmem),
    .busy(a_busy)
  );

  mvm_lif_array #(.LEAK_SHIFT(7)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_spikes(in_spikes), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .out_valid(b_out_valid), .out_spikes(b_out_spikes), .out_vmem(b_out_vmem),
    .busy(b_busy)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (one timestep at a time) ----------------
  int wm [NW];
  int va [4], vb [4];
  bit sa [4], sb [4];
  int ra [4], rb [4];
  int left = 0;

  function automatic int clampv(input int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  task automatic neuron(input int v, input int acc, input int ls, input int rc,
                        output int nv, output bit s, output int nrc);
    int x;
    nrc = rc;
`ifdef REFRACTORY_EN
    if (rc > 0) begin
      nv = 0; s = 1'b0; nrc = rc - 1;
      return;
    end
`endif
    x = clampv(v - (v >>> ls) + acc);
    if (x >= THR) begin
      nv = 0; s = 1'b1; nrc = REFRAC;
    end else begin
      nv = x; s = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NW; k++) wm[k] = 0;
      for (int j = 0; j < 4; j++) begin
        va[j] = 0; vb[j] = 0; sa[j] = 1'b0; sb[j] = 1'b0; ra[j] = 0; rb[j] = 0;
      end
      left = 0;
    end else if (left > 0) begin
      left--;
    end else begin
      if (w_we && int'(w_addr) < NW) wm[w_addr] = int'($signed(w_data));
      if (in_valid) begin
        for (int j = 0; j < 4; j++) begin
          int acc;
          acc = 0;
          for (int i = 0; i < 8; i++) if (in_spikes[i]) acc += wm[i*4 + j];
          neuron(va[j], acc, 1, ra[j], va[j], sa[j], ra[j]);
          neuron(vb[j], acc, 7, rb[j], vb[j], sb[j], rb[j]);
        end
        left = $countones(in_spikes) + 2;
      end
    end
  end

  // Compare process: status every cycle, data whenever it is settled.
  always @(negedge clk) begin
    logic [31:0] pa, pb;
    logic [3:0]  qa, qb;
    for (int j = 0; j < 4; j++) begin
      pa[j*8 +: 8] = 8'(va[j]);
      pb[j*8 +: 8] = 8'(vb[j]);
      qa[j] = sa[j];
      qb[j] = sb[j];
    end
    check("a_in_ready", {31'd0, a_in_ready}, {31'd0, left == 0});
    check("a_busy", {31'd0, a_busy}, {31'd0, left != 0});
    check("a_out_valid", {31'd0, a_out_valid}, {31'd0, left == 1});
    check("b_out_valid", {31'd0, b_out_valid}, {31'd0, left == 1});
    if (left <= 1) begin
      check("a_vmem", a_out_vmem, pa);
      check("a_spikes", {28'd0, a_out_spikes}, {28'd0, qa});
      check("b_vmem", b_out_vmem, pb);
      check("b_spikes", {28'd0, b_out_spikes}, {28'd0, qb});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready();
    int n;
    n = 0;
    while (!a_in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("ready_wait", {31'd0, a_in_ready}, 32'd1);
  endtask

  task automatic write_w(input int addr, input int data);
    wait_ready();
    w_we = 1'b1; w_addr = 5'(addr); w_data = 4'(data);
    @(posedge clk); #1;
    w_we = 1'b0;
  endtask

  task automatic fill_w(input int data);
    for (int k = 0; k < NW; k++) write_w(k, data);
  endtask

  task automatic wait_out(input int exp_lat, input string nm);
    int n;
    n = 1;
    while (!a_out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check(nm, n, exp_lat);
  endtask

  task automatic run_step(input logic [7:0] sp);
    wait_ready();
    in_valid = 1'b1; in_spikes = sp;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out($countones(sp) + 2, "latency");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int          leak_seq [6] = '{14, 21, 25, 27, 28, 28};
  int          sat_seq  [3] = '{-64, -127, -128};
  logic [7:0]  e8;

  initial begin
    do_reset();
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    check("rst_busy", {31'd0, a_busy}, 32'd0);
    check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("rst_spikes", {28'd0, a_out_spikes}, 32'd0);
    check("rst_vmem", a_out_vmem, 32'd0);

    // Sparsity latency with zero weights.
    run_step(8'h00);
    run_step(8'hFF);
    run_step(8'h81);

    // Integrate and fire.
    fill_w(7);
    run_step(8'hFF);
    check("if1_vmem", a_out_vmem, 32'h38383838);
    check("if1_spk", {28'd0, a_out_spikes}, 32'd0);
    run_step(8'hFF);
    check("if2_vmem", a_out_vmem, 32'h00000000);
    check("if2_spk", {28'd0, a_out_spikes}, 32'h0000000F);
    run_step(8'hFF);
`ifdef REFRACTORY_EN
    check("ref1_vmem", a_out_vmem, 32'h00000000);
    check("ref1_spk", {28'd0, a_out_spikes}, 32'd0);
`endif
    run_step(8'hFF);
`ifdef REFRACTORY_EN
    check("ref2_vmem", a_out_vmem, 32'h00000000);
    check("ref2_spk", {28'd0, a_out_spikes}, 32'd0);
`endif
    run_step(8'hFF);
`ifdef REFRACTORY_EN
    check("ref3_vmem", a_out_vmem, 32'h38383838);
`endif

    // Leak equilibrium: rows 0 and 3 at 7, v converges where ceil(v/2)+14 = v.
    do_reset();
    for (int j = 0; j < 4; j++) begin
      write_w(0*4 + j, 7);
      write_w(3*4 + j, 7);
    end
    for (int k = 0; k < 6; k++) begin
      run_step(8'h09);
      e8 = 8'(leak_seq[k]);
      check("leak_vmem", a_out_vmem, {4{e8}});
      check("leak_spk", {28'd0, a_out_spikes}, 32'd0);
    end

    // Negative saturation on the LEAK_SHIFT=7 instance.
    do_reset();
    fill_w(-8);
    for (int k = 0; k < 3; k++) begin
      run_step(8'hFF);
      e8 = 8'(sat_seq[k]);
      check("sat_vmem", b_out_vmem, {4{e8}});
      check("sat_spk", {28'd0, b_out_spikes}, 32'd0);
    end

    // Writes and inputs while busy are ignored.
    wait_ready();
    in_valid = 1'b1; in_spikes = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    w_we = 1'b1; w_addr = 5'd0; w_data = 4'd7;
    in_valid = 1'b1; in_spikes = 8'h01;
    @(posedge clk); #1;
    w_we = 1'b0; in_valid = 1'b0;
    wait_out(8, "busy_lat");
    run_step(8'h01);

    // Write coincident with accept is used by that timestep.
    wait_ready();
    w_we = 1'b1; w_addr = 5'd1; w_data = 4'd5;
    in_valid = 1'b1; in_spikes = 8'h01;
    @(posedge clk); #1;
    w_we = 1'b0; in_valid = 1'b0;
    wait_out(3, "coinc_lat");

    // Reset in the middle of ACCUM abandons the timestep.
    wait_ready();
    in_valid = 1'b1; in_spikes = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_ready", {31'd0, a_in_ready}, 32'd1);
    check("mid_rst_vmem", a_out_vmem, 32'd0);
    check("mid_rst_valid", {31'd0, a_out_valid}, 32'd0);
    repeat (12) begin @(posedge clk); #1; end

    // Randomised timesteps with interleaved weight updates.
    for (int it = 0; it < 60; it++) begin
      int nwr;
      nwr = $urandom_range(0, 4);
      for (int k = 0; k < nwr; k++) write_w($urandom_range(0, NW-1), $urandom_range(0, 15));
      run_step(8'($urandom));
    end
    repeat (4) begin @(posedge clk); #1; end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
